bounce_sched: RTL and testbench
===============================

// Module: bounce_sched
// PURPOSE
//   Per-frame motion scheduler for NUM_SPRITES bouncing boxes in the screensaver
//   image path. On each frame-counter change from video_timer it steps every sprite
//   through one shared adder/clamp unit, X first then Y, and recolours a sprite on an
//   edge hit. Sits between video_timer (frame) and the image renderer (positions,
//   colours). Velocities are reconfigured through a valid/ready port.
// PARAMETERS
//   NUM_SPRITES    2    sprites scheduled; >=1
//   SCREEN_WIDTH   640  visible width in pixels
//   SCREEN_HEIGHT  480  visible height in pixels
//   BOX_WIDTH      100  sprite width; X_MAX = SCREEN_WIDTH-BOX_WIDTH (540)
//   BOX_HEIGHT     100  sprite height; Y_MAX = SCREEN_HEIGHT-BOX_HEIGHT (380)
//   XW = $clog2(SCREEN_WIDTH)+1 (11), YW = $clog2(SCREEN_HEIGHT)+1 (10), IW = max(1,$clog2(NUM_SPRITES))
// PORTS
//   clk           in   1               pixel clock
//   rst           in   1               asynchronous reset, active-high
//   frame         in   32              frame counter from video_timer
//   pause         in   1               1 = skip updates (frames still tracked)
//   cfg_valid     in   1               velocity write request
//   cfg_ready     out  1               write accepted when cfg_valid&cfg_ready
//   cfg_idx       in   IW              target sprite
//   cfg_xv        in   XW              new signed X velocity
//   cfg_yv        in   YW              new signed Y velocity
//   box_x         out  NUM_SPRITES*XW  sprite i X at [i*XW +: XW], signed
//   box_y         out  NUM_SPRITES*YW  sprite i Y at [i*YW +: YW], signed
//   color         out  NUM_SPRITES*3   sprite i {b,g,r} at [i*3 +: 3]
//   busy          out  1               FSM not IDLE
//   update_done   out  1               1-cycle pulse, last sprite committed
//   overrun       out  1               sticky: frame change lost
// BEHAVIOUR
//   Reset (async): sprite i x=50+150*i, y=50+60*i, xv=2, yv=1, color=3'b111;
//     frame_prev=0, pending=0, overrun=0, FSM=IDLE, idx=0, update_done=0.
//     Reset value of frame from video_timer (all ones) differs -> first update right after reset.
//   Trigger: frame!=frame_prev seen on a cycle -> frame_prev<=frame that cycle.
//     pause=1: no update, no pending. Busy: pending<=1; if pending already 1 -> overrun<=1.
//   FSM: IDLE -> STEP_X (when trigger&!pause, or pending; pending cleared on entry)
//     STEP_X: tx=x[idx]+xv[idx] (XW signed); tx<0 -> x=0; tx>X_MAX -> x=X_MAX; else x=tx.
//             xhit=(tx<0)|(tx>=X_MAX); xhit -> xv=-xv (two's complement). -> STEP_Y
//     STEP_Y: same on y/yv/Y_MAX, yhit. xhit|yhit -> color = (color==7)?1:color+1.
//             idx==NUM_SPRITES-1 -> IDLE, idx=0, update_done=1; else idx++ -> STEP_X.
//   Latency: trigger cycle T; sprite k X at T+1+2k, Y/colour at T+2+2k; done at T+2*NUM_SPRITES.
//   Only one adder/clamp: one axis of one sprite per cycle; outputs change only at commit edges.
//   cfg_ready = (FSM==IDLE) & !(trigger&!pause) & !pending; accepted write replaces xv,yv of
//     cfg_idx next edge; position/colour untouched; cfg_idx>=NUM_SPRITES ignored (still accepted).
//   Velocity 0 allowed: no motion, hit only if already at 0 or limit.
//   busy = FSM!=IDLE. pause mid-update: current sweep completes.
//   All arithmetic signed; sums wrap at XW/YW bits; |v| must stay < BOX size.
// TESTING
//   rst then release, frame=~0 -> sweep: sprite0 (52,51), sprite1 (202,111), done at T+4, colours 7.
//   sprite0 x=538,xv=2 -> tx=540: x=540, xv=-2, colour 7->1; next frame x=538.
//   sprite0 y=1,yv=-3 -> ty=-2: y=0, yv=3, colour 1->2; X and Y hit same frame -> one increment.
//   frame changes at T and T+1 (busy) -> pending, second sweep follows; third change -> overrun=1.
//   pause=1 over 3 frame changes -> positions frozen, no pending; pause=0 -> next change updates.
//   cfg write during busy -> cfg_ready=0 held until IDLE; rst asserted mid-sweep -> all reset values at once.

Source files
------------

// File: rtl/bounce_sched.sv
// Per-frame bounce scheduler: on each frame change every sprite is stepped X then Y
// through a single shared adder/clamp, with a colour advance whenever an edge is hit.
module bounce_sched #(
  parameter int NUM_SPRITES   = 2,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BOX_WIDTH     = 100,
  parameter int BOX_HEIGHT    = 100,
  localparam int XW = $clog2(SCREEN_WIDTH) + 1,
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1,
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               frame,
  input  logic                      pause,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [IW-1:0]             cfg_idx,
  input  logic [XW-1:0]             cfg_xv,
  input  logic [YW-1:0]             cfg_yv,
  output logic [NUM_SPRITES*XW-1:0] box_x,
  output logic [NUM_SPRITES*YW-1:0] box_y,
  output logic [NUM_SPRITES*3-1:0]  color,
  output logic                      busy,
  output logic                      update_done,
  output logic                      overrun
);
  localparam int X_MAX = SCREEN_WIDTH - BOX_WIDTH;
  localparam int Y_MAX = SCREEN_HEIGHT - BOX_HEIGHT;
  localparam int AW    = (XW > YW) ? XW : YW;

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [31:0]          frame_prev_q, frame_prev_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic                 done_q, done_d;
  logic                 xhit_q, xhit_d;
  logic signed [XW-1:0] x_q  [NUM_SPRITES];
  logic signed [XW-1:0] x_d  [NUM_SPRITES];
  logic signed [XW-1:0] xv_q [NUM_SPRITES];
  logic signed [XW-1:0] xv_d [NUM_SPRITES];
  logic signed [YW-1:0] y_q  [NUM_SPRITES];
  logic signed [YW-1:0] y_d  [NUM_SPRITES];
  logic signed [YW-1:0] yv_q [NUM_SPRITES];
  logic signed [YW-1:0] yv_d [NUM_SPRITES];
  logic [2:0]           color_q [NUM_SPRITES];
  logic [2:0]           color_d [NUM_SPRITES];

  logic                 trigger, start;
  logic signed [AW-1:0] op_p, op_v, lim, sum_full, sum, clamped, v_next;
  logic signed [XW-1:0] sum_xw;
  logic signed [YW-1:0] sum_yw;
  logic                 neg, hit;

  assign trigger = (frame != frame_prev_q);
  assign start   = trigger & ~pause;

  // Shared adder/clamp; the Y sum is wrapped at YW bits before clamping
  always_comb begin
    if (state_q == STEP_Y) begin
      op_p = AW'(y_q[idx_q]);
      op_v = AW'(yv_q[idx_q]);
      lim  = AW'(Y_MAX);
    end else begin
      op_p = AW'(x_q[idx_q]);
      op_v = AW'(xv_q[idx_q]);
      lim  = AW'(X_MAX);
    end
    sum_full = op_p + op_v;
    sum_xw   = XW'(sum_full);
    sum_yw   = YW'(sum_full);
    sum      = (state_q == STEP_Y) ? AW'(sum_yw) : AW'(sum_xw);
    neg      = sum[AW-1];
    hit      = neg | (sum >= lim);
    if (neg)            clamped = '0;
    else if (sum > lim) clamped = lim;
    else                clamped = sum;
    v_next = hit ? -op_v : op_v;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_prev_d = frame;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    done_d       = 1'b0;
    xhit_d       = xhit_q;
    x_d          = x_q;
    y_d          = y_q;
    xv_d         = xv_q;
    yv_d         = yv_q;
    color_d      = color_q;
    cfg_ready    = (state_q == IDLE) & ~start & ~pending_q;

    case (state_q)
      IDLE: begin
        if (start || pending_q) begin
          state_d   = STEP_X;
          // a queued sweep and a fresh frame together leave one still queued
          pending_d = pending_q & start;
        end
      end
      STEP_X: begin
        x_d[idx_q]  = XW'(clamped);
        xv_d[idx_q] = XW'(v_next);
        xhit_d      = hit;
        state_d     = STEP_Y;
      end
      STEP_Y: begin
        y_d[idx_q]  = YW'(clamped);
        yv_d[idx_q] = YW'(v_next);
        if (hit || xhit_q)
          color_d[idx_q] = (color_q[idx_q] == 3'd7) ? 3'd1 : color_q[idx_q] + 3'd1;
        if (idx_q == IW'(NUM_SPRITES - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = STEP_X;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && start) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end

    if (cfg_valid && cfg_ready && (int'(cfg_idx) < NUM_SPRITES)) begin
      xv_d[cfg_idx] = cfg_xv;
      yv_d[cfg_idx] = cfg_yv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_prev_q <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      done_q       <= 1'b0;
      xhit_q       <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]     <= XW'(50 + 150 * i);
        y_q[i]     <= YW'(50 + 60 * i);
        xv_q[i]    <= XW'(2);
        yv_q[i]    <= YW'(1);
        color_q[i] <= 3'b111;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_prev_q <= frame_prev_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      done_q       <= done_d;
      xhit_q       <= xhit_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xv_q         <= xv_d;
      yv_q         <= yv_d;
      color_q      <= color_d;
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign box_x[g*XW +: XW] = x_q[g];
    assign box_y[g*YW +: YW] = y_q[g];
    assign color[g*3 +: 3]   = color_q[g];
  end

  assign busy        = (state_q != IDLE);
  assign update_done = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_bounce_sched.sv
// Bench for bounce_sched: per-frame physics model plus commit-timing, handshake and reset checks.
module tb_bounce_sched;
  localparam int N     = 2;
  localparam int XW    = 11;
  localparam int YW    = 10;
  localparam int IW    = 1;
  localparam int X_MAX = 540;
  localparam int Y_MAX = 380;
  localparam int VW    = N * (XW + YW + 3);

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     frame;
  logic            pause, cfg_valid, cfg_ready;
  logic [IW-1:0]   cfg_idx;
  logic [XW-1:0]   cfg_xv;
  logic [YW-1:0]   cfg_yv;
  logic [N*XW-1:0] box_x;
  logic [N*YW-1:0] box_y;
  logic [N*3-1:0]  color;
  logic            busy, update_done, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int mx[N], my[N], mvx[N], mvy[N], mc[N];

  bounce_sched #(.NUM_SPRITES(N)) dut (
    .clk(clk), .rst(rst), .frame(frame), .pause(pause),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_xv(cfg_xv), .cfg_yv(cfg_yv), .box_x(box_x), .box_y(box_y),
    .color(color), .busy(busy), .update_done(update_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int s = 0; s < N; s++) begin
      mx[s] = 50 + 150 * s; my[s] = 50 + 60 * s;
      mvx[s] = 2; mvy[s] = 1; mc[s] = 7;
    end
  endfunction

  // One frame of motion for every sprite, straight from the bounce rules
  function automatic void model_sweep();
    for (int s = 0; s < N; s++) begin
      int t;
      bit hx, hy;
      t = mx[s] + mvx[s];
      hx = (t < 0) || (t >= X_MAX);
      mx[s] = (t < 0) ? 0 : ((t > X_MAX) ? X_MAX : t);
      if (hx) mvx[s] = -mvx[s];
      t = my[s] + mvy[s];
      hy = (t < 0) || (t >= Y_MAX);
      my[s] = (t < 0) ? 0 : ((t > Y_MAX) ? Y_MAX : t);
      if (hy) mvy[s] = -mvy[s];
      if (hx || hy) mc[s] = (mc[s] == 7) ? 1 : mc[s] + 1;
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [N*XW-1:0] vx;
    logic [N*YW-1:0] vy;
    logic [N*3-1:0]  vc;
    for (int s = 0; s < N; s++) begin
      vx[s*XW +: XW] = XW'(mx[s]);
      vy[s*YW +: YW] = YW'(my[s]);
      vc[s*3 +: 3]   = 3'(mc[s]);
    end
    return {vx, vy, vc};
  endfunction

  function automatic int x_of(input int s);
    return int'($signed(box_x[s*XW +: XW]));
  endfunction

  function automatic int y_of(input int s);
    return int'($signed(box_y[s*YW +: YW]));
  endfunction

  task automatic cfg_write(input int idx, input int vx, input int vy);
    int cyc = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = IW'(idx); cfg_xv = XW'(vx); cfg_yv = YW'(vy);
    #1;
    while (!cfg_ready && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL cfg_timeout ready=%0b want=1", cfg_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (idx < N) begin mvx[idx] = vx; mvy[idx] = vy; end
  endtask

  // Frame change (or reset release) then cycle-by-cycle commit timing of the sweep
  task automatic do_frame(input bit p, input bit rel);
    int ox[N], oy[N], oc[N];
    int ex, ey, ec;
    bit eb, ed;
    ox = mx; oy = my; oc = mc;
    @(negedge clk);
    pause = p;
    if (rel) rst = 1'b0; else frame = frame + 32'd1;
    if (!p) model_sweep();
    #1;
    n_cmp++;
    if (cfg_ready !== p) begin
      n_bad++; $display("FAIL trig_ready got=%0b want=%0b", cfg_ready, p);
    end
    for (int k = 1; k <= 2*N + 2; k++) begin
      @(negedge clk);
      eb = !p && (k <= 2*N);
      ed = !p && (k == 2*N + 1);
      n_cmp++;
      if (busy !== eb || update_done !== ed || cfg_ready !== !eb) begin
        n_bad++;
        $display("FAIL sweep_ctl k=%0d busy/done/rdy=%0b%0b%0b want=%0b%0b%0b",
                 k, busy, update_done, cfg_ready, eb, ed, !eb);
      end
      for (int s = 0; s < N; s++) begin
        ex = (!p && k >= 2 + 2*s) ? mx[s] : ox[s];
        ey = (!p && k >= 3 + 2*s) ? my[s] : oy[s];
        ec = (!p && k >= 3 + 2*s) ? mc[s] : oc[s];
        n_cmp++;
        if (x_of(s) !== ex || y_of(s) !== ey || int'(color[s*3 +: 3]) !== ec) begin
          n_bad++;
          $display("FAIL sweep_pos k=%0d s=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                   k, s, x_of(s), y_of(s), color[s*3 +: 3], ex, ey, ec);
        end
      end
      pause = 1'($urandom);
    end
    pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame = '1; pause = 1'b0; cfg_valid = 1'b0;
    cfg_idx = '0; cfg_xv = '0; cfg_yv = '0;
    repeat (3) @(negedge clk);
    model_reset();
    n_cmp++;
    if ({box_x, box_y, color} !== model_vec() || busy !== 1'b0 ||
        update_done !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got=%h busy=%0b done=%0b ovr=%0b want=%h 0 0 0",
               {box_x, box_y, color}, busy, update_done, overrun, model_vec());
    end
    do_frame(1'b0, 1'b1);
    n_cmp++;
    if (x_of(0) !== 52 || y_of(0) !== 51 || x_of(1) !== 202 || y_of(1) !== 111 ||
        color !== 6'b111111) begin
      n_bad++;
      $display("FAIL first_sweep got=(%0d,%0d)(%0d,%0d) c=%b want=(52,51)(202,111) c=111111",
               x_of(0), y_of(0), x_of(1), y_of(1), color);
    end
  endtask

  task automatic test_edge_x();
    cfg_write(0, 81, 0);
    for (int i = 0; i < 6; i++) do_frame(1'b0, 1'b0);
    n_cmp++;
    if (x_of(0) !== 538) begin n_bad++; $display("FAIL edge_x_pre x=%0d want=538", x_of(0)); end
    cfg_write(0, 2, 0);
    do_frame(1'b0, 1'b0);
    n_cmp++;
    if (x_of(0) !== 540 || color[2:0] !== 3'd1) begin
      n_bad++; $display("FAIL edge_x_hit x=%0d c=%0d want=540 c=1", x_of(0), color[2:0]);
    end
    do_frame(1'b0, 1'b0);
    n_cmp++;
    if (x_of(0) !== 538) begin n_bad++; $display("FAIL edge_x_rev x=%0d want=538", x_of(0)); end
  endtask

  task automatic test_edge_y();
    cfg_write(0, 0, -50);
    do_frame(1'b0, 1'b0);
    cfg_write(0, 0, -3);
    do_frame(1'b0, 1'b0);
    n_cmp++;
    if (y_of(0) !== 0 || color[2:0] !== 3'd2) begin
      n_bad++; $display("FAIL edge_y_hit y=%0d c=%0d want=0 c=2", y_of(0), color[2:0]);
    end
    do_frame(1'b0, 1'b0);
    n_cmp++;
    if (y_of(0) !== 3) begin n_bad++; $display("FAIL edge_y_rev y=%0d want=3", y_of(0)); end
    cfg_write(0, 2, -4);
    do_frame(1'b0, 1'b0);
    n_cmp++;
    if (x_of(0) !== 540 || y_of(0) !== 0 || color[2:0] !== 3'd3) begin
      n_bad++;
      $display("FAIL edge_xy_once x=%0d y=%0d c=%0d want=540 0 3", x_of(0), y_of(0), color[2:0]);
    end
  endtask

  task automatic test_pending();
    int dones;
    for (int round = 0; round < 2; round++) begin
      dones = 0;
      @(negedge clk); frame = frame + 32'd1; model_sweep();
      @(negedge clk); frame = frame + 32'd1; model_sweep();
      if (round == 1) begin @(negedge clk); frame = frame + 32'd1; end
      for (int k = 0; k < 14; k++) begin
        @(negedge clk);
        if (update_done) begin
          dones++;
          if (dones == 1) begin
            n_cmp++;
            if (cfg_ready !== 1'b0) begin
              n_bad++; $display("FAIL pend_ready rdy=%0b want=0", cfg_ready);
            end
          end
        end
      end
      n_cmp++;
      if (dones !== 2 || overrun !== 1'(round)) begin
        n_bad++;
        $display("FAIL pending_r%0d dones=%0d ovr=%0b want=2 %0d", round, dones, overrun, round);
      end
      n_cmp++;
      if ({box_x, box_y, color} !== model_vec()) begin
        n_bad++;
        $display("FAIL pending_pos_r%0d got=%h want=%h", round, {box_x, box_y, color}, model_vec());
      end
    end
  endtask

  task automatic test_pause();
    int dones = 0;
    for (int i = 0; i < 3; i++) do_frame(1'b1, 1'b0);
    @(negedge clk); pause = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL unpause_idle busy=%0b want=0", busy); end
    @(negedge clk); frame = frame + 32'd1; model_sweep();
    @(negedge clk); pause = 1'b1; frame = frame + 32'd1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (update_done) dones++;
    end
    pause = 1'b0;
    n_cmp++;
    if (dones !== 1 || {box_x, box_y, color} !== model_vec()) begin
      n_bad++;
      $display("FAIL pause_busy dones=%0d got=%h want=1 %h", dones, {box_x, box_y, color}, model_vec());
    end
    do_frame(1'b0, 1'b0);
  endtask

  task automatic test_cfg_busy();
    @(negedge clk); frame = frame + 32'd1; model_sweep();
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = 1'b1; cfg_xv = XW'(-7); cfg_yv = YW'(5);
    for (int k = 1; k <= 2*N; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      n_cmp++;
      if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL cfg_busy k=%0d rdy=%0b busy=%0b want=0 1", k, cfg_ready, busy);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL cfg_idle rdy=%0b busy=%0b want=1 0", cfg_ready, busy);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0; mvx[1] = -7; mvy[1] = 5;
    n_cmp++;
    if ({box_x, box_y, color} !== model_vec()) begin
      n_bad++; $display("FAIL cfg_nomove got=%h want=%h", {box_x, box_y, color}, model_vec());
    end
    do_frame(1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(2) == 0)
        cfg_write(int'($urandom_range(N - 1)), int'($urandom_range(198)) - 99,
                  int'($urandom_range(198)) - 99);
      do_frame($urandom_range(3) == 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk); frame = frame + 32'd1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({box_x, box_y, color} !== model_vec() || busy !== 1'b0 ||
        update_done !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got=%h busy=%0b done=%0b ovr=%0b want=%h 0 0 0",
               {box_x, box_y, color}, busy, update_done, overrun, model_vec());
    end
    repeat (2) @(negedge clk);
    do_frame(1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_edge_x();
    test_edge_y();
    test_pending();
    test_pause();
    test_cfg_busy();
    test_random();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
